// File: rtl/flash_seq_pkg.sv
// flash_seq shared constants: SPI opcodes, engine operation codes,
// host request encodings and sequencer states.
package flash_seq_pkg;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_RDID = 8'h90;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  localparam logic [2:0] CT_RDID  = 3'b000;
  localparam logic [2:0] CT_WREN  = 3'b001;
  localparam logic [2:0] CT_ERASE = 3'b010;
  localparam logic [2:0] CT_RDSR  = 3'b011;
  localparam logic [2:0] CT_PROG  = 3'b101;
  localparam logic [2:0] CT_READ  = 3'b111;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_ERASE = 2'b01,
    OP_PROG  = 2'b10,
    OP_RDID  = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    IDLE,
    WREN,
    WREN_WAIT,
    OP,
    OP_WAIT,
    POLL,
    POLL_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/flash_cmd_issue.sv
// Launches one SPI engine transaction: one-cycle start pulse, holds the
// command fields stable and tracks busy until the engine reports done.
module flash_cmd_issue
  import flash_seq_pkg::*;
(
  input  logic        clock25M,
  input  logic        flash_rstn,
  input  logic        launch,
  input  logic [2:0]  launch_type,
  input  logic [7:0]  launch_cmd,
  input  logic [23:0] launch_addr,
  input  logic [7:0]  launch_data,
  input  logic        Done_Sig,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  output logic [7:0]  wrdata,
  output logic        busy,
  output logic        done
);

  // Done_Sig outside a transaction is stray and never reaches the FSM
  assign done = busy & Done_Sig;

  always_ff @(posedge clock25M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      cmd_type   <= '0;
      flash_cmd  <= '0;
      flash_addr <= '0;
      wrdata     <= '0;
      busy       <= 1'b0;
    end else begin
      cmd_type[3] <= launch;
      if (launch) begin
        cmd_type[2:0] <= launch_type;
        flash_cmd     <= launch_cmd;
        flash_addr    <= launch_addr;
        wrdata        <= launch_data;
        busy          <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_seq.sv
// SPI flash operation sequencer: read/ID/erase/program with WIP polling.
// Optional poll timeout enabled by defining FLASH_SEQ_TIMEOUT_EN.
module flash_seq
  import flash_seq_pkg::*;
#(
  parameter int unsigned MAX_POLLS = 20000,
  parameter logic [7:0]  RDSR_CMD  = OPC_RDSR
) (
  input  logic        clock25M,
  input  logic        flash_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        op_done,
  output logic        op_err,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  output logic [7:0]  wrdata,
  input  logic        Done_Sig,
  input  logic [7:0]  mydata_o,
  input  logic        myvalid_o
);

  state_e      state, state_nxt;
  req_op_e     op_q;
  logic [23:0] addr_q;
  logic [7:0]  wdata_q;
  logic        wip_q;
  logic        accept, is_read, req_is_read;
  logic        wip, rd_take, poll_limit;
  logic        launch, busy, done;
  logic [2:0]  l_type;
  logic [7:0]  l_cmd;

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid & req_ready;
  assign req_is_read = (req_op_e'(req_op) == OP_READ) |
                       (req_op_e'(req_op) == OP_RDID);
  assign is_read     = (op_q == OP_READ) | (op_q == OP_RDID);
  // status byte may land in the same cycle as Done_Sig
  assign wip         = myvalid_o ? mydata_o[0] : wip_q;
  assign rd_take     = myvalid_o & is_read & (state == OP_WAIT);
  assign op_done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    l_type    = CT_RDID;
    l_cmd     = 8'h00;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = req_is_read ? OP : WREN;
      end
      WREN: begin
        if (!busy) begin
          launch    = 1'b1;
          l_type    = CT_WREN;
          l_cmd     = OPC_WREN;
          state_nxt = WREN_WAIT;
        end
      end
      WREN_WAIT: begin
        if (done) state_nxt = OP;
      end
      OP: begin
        if (!busy) begin
          launch    = 1'b1;
          state_nxt = OP_WAIT;
          unique case (op_q)
            OP_READ:  begin l_type = CT_READ;  l_cmd = OPC_READ; end
            OP_RDID:  begin l_type = CT_RDID;  l_cmd = OPC_RDID; end
            OP_ERASE: begin l_type = CT_ERASE; l_cmd = OPC_SE;   end
            OP_PROG:  begin l_type = CT_PROG;  l_cmd = OPC_PP;   end
          endcase
        end
      end
      OP_WAIT: begin
        if (done) state_nxt = is_read ? DONE : POLL;
      end
      POLL: begin
        if (!busy) begin
          launch    = 1'b1;
          l_type    = CT_RDSR;
          l_cmd     = RDSR_CMD;
          state_nxt = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (done) state_nxt = (!wip || poll_limit) ? DONE : POLL;
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock25M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      state    <= IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      wip_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_take;
      if (accept) begin
        op_q    <= req_op_e'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == POLL_WAIT && myvalid_o) wip_q <= mydata_o[0];
      if (rd_take) rd_data <= mydata_o;
    end
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);
  logic [15:0] poll_cnt;
  logic        err_q;

  assign poll_limit = (poll_cnt >= POLL_LAST);
  assign op_err     = (state == DONE) & err_q;

  always_ff @(posedge clock25M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      poll_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) err_q <= 1'b0;
      if (state == WREN) poll_cnt <= '0;
      else if (state == POLL_WAIT && done) poll_cnt <= poll_cnt + 16'd1;
      if (state == POLL_WAIT && done && wip && poll_limit) err_q <= 1'b1;
    end
  end
`else
  assign poll_limit = 1'b0;
  assign op_err     = 1'b0;
  if (MAX_POLLS == 0) begin : g_unbounded_poll
  end
`endif

  flash_cmd_issue u_issue (
    .clock25M    (clock25M),
    .flash_rstn  (flash_rstn),
    .launch      (launch),
    .launch_type (l_type),
    .launch_cmd  (l_cmd),
    .launch_addr (addr_q),
    .launch_data (wdata_q),
    .Done_Sig    (Done_Sig),
    .cmd_type    (cmd_type),
    .flash_cmd   (flash_cmd),
    .flash_addr  (flash_addr),
    .wrdata      (wrdata),
    .busy        (busy),
    .done        (done)
  );

endmodule
